// File: rtl/down_timer_pkg.sv
// Shared state encoding and helpers for the down_timer block.
package down_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == RUN) || (s == HOLD);
   endfunction

endpackage

// File: rtl/down_timer_prescaler.sv
// Tick strobe generator: one tick every prescale_i+1 enabled cycles.
module down_timer_prescaler #(
   parameter int PrescaleSize = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic [PrescaleSize-1:0] prescale_i,
   output logic                    tick_o
);

   logic [PrescaleSize-1:0] cnt_q, cnt_d;

   assign tick_o = enable_i && (cnt_q == prescale_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/down_timer.sv
// Loadable down counter with pause/abort and optional auto-reload.
// Define DOWN_TIMER_PRESCALE_EN to add the prescale_i tick divisor.
module down_timer
   import down_timer_pkg::*;
#(
   parameter int Size         = 8,
   parameter int PrescaleSize = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic [Size-1:0]         data_i,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    reload,
`ifdef DOWN_TIMER_PRESCALE_EN
   input  logic [PrescaleSize-1:0] prescale_i,
`endif
   output logic [Size-1:0]         data_o,
   output logic                    busy,
   output logic                    done
);

   state_e          state_q, state_d;
   logic [Size-1:0] count_q, count_d;
   logic [Size-1:0] reload_q, reload_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            start_ok;
   logic            run_entry;
   logic            tick_en;
   logic            tick;

   // Start is only honoured from HOLD, or from IDLE with something to count.
   assign start_ok  = start && ((state_q == HOLD) ||
                                ((state_q == IDLE) && (count_q != '0)));
   assign run_entry = !load && !stop && start_ok && (state_q == IDLE);
   assign tick_en   = (state_q == RUN) && !load && !stop;

`ifdef DOWN_TIMER_PRESCALE_EN
   down_timer_prescaler #(
      .PrescaleSize(PrescaleSize)
   ) u_prescaler (
      .clock      (clock),
      .reset      (reset),
      .clear_i    (load || run_entry),
      .enable_i   (tick_en),
      .prescale_i (prescale_i),
      .tick_o     (tick)
   );
`else
   assign tick = tick_en;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         count_d  = data_i;
         reload_d = data_i;
         state_d  = IDLE;
      end else if (stop) begin
         if (state_q == RUN) begin
            state_d = HOLD;
         end else if (state_q == HOLD) begin
            state_d = IDLE;
         end
      end else if (start_ok) begin
         state_d = RUN;
      end else if (tick) begin
         if (count_q > Size'(1)) begin
            count_d = count_q - 1'b1;
         end else if (count_q == Size'(1)) begin
            done_d = 1'b1;
            if (reload) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = IDLE;
            end
         end
      end
      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign data_o = count_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: vector table plus hand-written corner sequences.
module tb_down_timer;

   logic       clock = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] data_i;
   logic       start;
   logic       stop;
   logic       reload;
`ifdef DOWN_TIMER_PRESCALE_EN
   logic [3:0] prescale_i;
`endif
   logic [7:0] data_o;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit       ld;
      bit [7:0] d;
      bit       st;
      bit       sp;
      bit       rl;
      bit [7:0] exp_data;
      bit       exp_busy;
      bit       exp_done;
      string    name;
   } vec_t;

   vec_t vecs[$];

   down_timer #(
      .Size         (8),
      .PrescaleSize (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .data_i     (data_i),
      .start      (start),
      .stop       (stop),
      .reload     (reload),
`ifdef DOWN_TIMER_PRESCALE_EN
      .prescale_i (prescale_i),
`endif
      .data_o     (data_o),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic [7:0] ed, input logic eb, input logic edn);
      check({nm, ".data"}, 32'(data_o), 32'(ed));
      check({nm, ".busy"}, 32'(busy), 32'(eb));
      check({nm, ".done"}, 32'(done), 32'(edn));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic ld, input logic [7:0] d, input logic st, input logic sp, input logic rl);
      load   = ld;
      data_i = d;
      start  = st;
      stop   = sp;
      reload = rl;
   endtask

   task automatic add(input bit ld, input bit [7:0] d, input bit st, input bit sp, input bit rl,
                      input bit [7:0] ed, input bit eb, input bit edn, input string nm);
      vec_t v;
      v.ld = ld; v.d = d; v.st = st; v.sp = sp; v.rl = rl;
      v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      //   ld d   st sp rl  data busy done
      add(1, 5,  0, 0, 0,  5,   0,   0, "load5");
      add(0, 0,  1, 0, 0,  5,   1,   0, "start5");
      add(0, 0,  0, 0, 0,  4,   1,   0, "cnt4");
      add(0, 0,  0, 0, 0,  3,   1,   0, "cnt3");
      add(0, 0,  0, 0, 0,  2,   1,   0, "cnt2");
      add(0, 0,  0, 0, 0,  1,   1,   0, "cnt1");
      add(0, 0,  0, 0, 0,  0,   0,   1, "term0");
      add(0, 0,  0, 0, 0,  0,   0,   0, "after_done");
      add(0, 0,  1, 0, 0,  0,   0,   0, "start_zero");
      add(0, 0,  0, 0, 0,  0,   0,   0, "stay_idle");
      add(1, 3,  0, 0, 1,  3,   0,   0, "load3");
      add(0, 0,  1, 0, 1,  3,   1,   0, "start3");
      add(0, 0,  0, 0, 1,  2,   1,   0, "rl2a");
      add(0, 0,  0, 0, 1,  1,   1,   0, "rl1a");
      add(0, 0,  0, 0, 1,  3,   1,   1, "rl3a");
      add(0, 0,  0, 0, 1,  2,   1,   0, "rl2b");
      add(0, 0,  0, 0, 1,  1,   1,   0, "rl1b");
      add(0, 0,  0, 0, 1,  3,   1,   1, "rl3b");
      add(0, 0,  0, 0, 1,  2,   1,   0, "rl2c");
      add(1, 6,  0, 0, 0,  6,   0,   0, "load6");
      add(0, 0,  1, 0, 0,  6,   1,   0, "start6");
      add(0, 0,  0, 0, 0,  5,   1,   0, "cnt5");
      add(0, 0,  0, 0, 0,  4,   1,   0, "cnt4b");
      add(1, 9,  0, 0, 0,  9,   0,   0, "load9_run");
      add(0, 0,  0, 0, 0,  9,   0,   0, "idle9");
      add(1, 1,  0, 0, 0,  1,   0,   0, "load1");
      add(0, 0,  1, 0, 0,  1,   1,   0, "start1");
      add(1, 7,  0, 0, 0,  7,   0,   0, "load_over_term");
      add(0, 0,  0, 0, 0,  7,   0,   0, "no_done");
      add(0, 0,  0, 1, 0,  7,   0,   0, "stop_idle");
      add(0, 0,  1, 1, 0,  7,   0,   0, "stop_beats_start");
      add(0, 0,  1, 0, 0,  7,   1,   0, "start7");
      add(0, 0,  1, 0, 0,  6,   1,   0, "start_in_run");
      add(0, 0,  1, 1, 0,  6,   1,   0, "stop_to_hold");
      add(0, 0,  0, 0, 0,  6,   1,   0, "hold6");
      add(0, 0,  0, 1, 0,  6,   0,   0, "abort_hold");
      add(0, 0,  0, 0, 0,  6,   0,   0, "idle6");

      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
`ifdef DOWN_TIMER_PRESCALE_EN
      prescale_i = 4'd0;
`endif
      step();
      step();
      check_all("reset", 8'd0, 1'b0, 1'b0);
      drive(1, 8'h55, 1, 0, 0);
      step();
      check_all("reset_over_load", 8'd0, 1'b0, 1'b0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].sp, vecs[i].rl);
         step();
         check_all(vecs[i].name, vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_done);
      end

      // Pause at 7, hold four cycles, resume.
      drive(1, 10, 0, 0, 0); step();
      drive(0, 0, 1, 0, 0);  step();
      drive(0, 0, 0, 0, 0);  step(); step(); step();
      check_all("pre_stop", 8'd7, 1'b1, 1'b0);
      drive(0, 0, 0, 1, 0);  step();
      check_all("stop_at7", 8'd7, 1'b1, 1'b0);
      drive(0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         check_all("hold7", 8'd7, 1'b1, 1'b0);
      end
      drive(0, 0, 1, 0, 0);  step();
      check_all("resume", 8'd7, 1'b1, 1'b0);
      drive(0, 0, 0, 0, 0);  step();
      check_all("resume_tick", 8'd6, 1'b1, 1'b0);

      // Reset mid-count, then a start that must be ignored.
      drive(1, 5, 0, 0, 0); step();
      drive(0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 0, 0); step();
      check_all("pre_reset", 8'd4, 1'b1, 1'b0);
      reset = 1'b1; step();
      check_all("reset_run", 8'd0, 1'b0, 1'b0);
      reset = 1'b0;
      drive(0, 0, 1, 0, 0); step();
      check_all("start_after_reset", 8'd0, 1'b0, 1'b0);
      drive(0, 0, 0, 0, 0); step();
      check_all("idle_after_reset", 8'd0, 1'b0, 1'b0);

`ifdef DOWN_TIMER_PRESCALE_EN
      prescale_i = 4'd2;
      drive(1, 2, 0, 0, 0); step();
      drive(0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 0, 0);
      step(); check_all("ps_c1", 8'd2, 1'b1, 1'b0);
      step(); check_all("ps_c2", 8'd2, 1'b1, 1'b0);
      step(); check_all("ps_c3", 8'd1, 1'b1, 1'b0);
      step(); check_all("ps_c4", 8'd1, 1'b1, 1'b0);
      step(); check_all("ps_c5", 8'd1, 1'b1, 1'b0);
      step(); check_all("ps_c6", 8'd0, 1'b0, 1'b1);
      step(); check_all("ps_c7", 8'd0, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter Size, default 8: count width in bits.
REQ-002 Parameter PrescaleSize, default 4: prescale field width; used only when DOWN_TIMER_PRESCALE_EN is defined.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  load data_i into count and reload register; return to IDLE.
REQ-006 data_i  input  Size  load value.
REQ-007 start  input  1  begin or resume counting.
REQ-008 stop  input  1  pause (RUN) or abort (HOLD).
REQ-009 reload  input  1  auto-reload mode select, sampled on each terminal tick.
REQ-010 prescale_i  input  PrescaleSize  tick divisor minus one; port present only with DOWN_TIMER_PRESCALE_EN.
REQ-011 data_o  output  Size  current count, registered.
REQ-012 busy  output  1  high while state is RUN or HOLD.
REQ-013 done  output  1  one-cycle pulse after a terminal tick.

Function
REQ-014 States SHALL be IDLE, RUN and HOLD; the state register and all outputs SHALL be registered.
REQ-015 Per-edge priority SHALL be reset > load > stop > start > tick.
REQ-016 load in any state SHALL set data_o and reload_reg to data_i, state to IDLE, done to 0, and SHALL discard any same-cycle tick.
REQ-017 IDLE with start and data_o != 0 SHALL go to RUN; start with data_o == 0 SHALL be ignored.
REQ-018 RUN with stop SHALL go to HOLD; HOLD with start SHALL go to RUN; HOLD with stop SHALL go to IDLE, keeping data_o.
REQ-019 In RUN, each tick with data_o > 1 SHALL decrement data_o by 1; no tick SHALL occur in the cycle RUN is entered.
REQ-020 A tick with data_o == 1 (terminal tick) SHALL set done = 1 on the next edge, and:
  - reload = 0: data_o <= 0, state <= IDLE.
  - reload = 1: data_o <= reload_reg, state stays RUN.
REQ-021 data_o SHALL never wrap below 0.
REQ-022 done SHALL be high for exactly one cycle per terminal tick.
REQ-023 busy SHALL fall in the same cycle done rises when reload = 0.
REQ-024 Without prescaling, every RUN cycle after entry SHALL be a tick.

Reset
REQ-025 reset SHALL set state = IDLE, data_o = 0, reload_reg = 0, busy = 0, done = 0 and prescale counter = 0, overriding all other inputs, including mid-count.

Configuration
REQ-026 When DOWN_TIMER_PRESCALE_EN is defined:
  - prescale_i SHALL exist.
  - A tick SHALL occur once every prescale_i+1 RUN cycles.
  - The prescale counter SHALL clear on reset, load and IDLE->RUN, and SHALL hold in HOLD.
REQ-027 When DOWN_TIMER_PRESCALE_EN is undefined, prescale_i and the prescale logic SHALL be absent and REQ-024 SHALL apply.

Structure
REQ-028 Package down_timer_pkg SHALL hold the state typedef (IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10).
REQ-029 Sub-module down_timer_prescaler SHALL produce the tick strobe and SHALL be instantiated only under DOWN_TIMER_PRESCALE_EN.

Verification (Size = 8)
REQ-030 Load 5, reload = 0, start at edge k -> data_o = 4 after edge k+1 and 0 after edge k+5; done = 1 for the single cycle after edge k+5; busy low from edge k+5.
REQ-031 Load 3, reload = 1, start -> data_o cycles 3,2,1,3,2,1; done pulses once per return to 3; busy stays 1.
REQ-032 Load 10, start, stop when data_o = 7, hold 4 cycles, then start -> data_o = 7 throughout HOLD, then 6 on the first tick after resume; no done.
REQ-033 Load 9 while RUN with data_o = 4 -> data_o = 9 next cycle, state IDLE, busy = 0, done = 0.
REQ-034 reset while RUN, then start -> data_o = 0, busy = 0, done = 0; start ignored and state stays IDLE.
REQ-035 With DOWN_TIMER_PRESCALE_EN: prescale_i = 2, load 2, start -> data_o = 1 three cycles after RUN entry, 0 after six; done pulses once.
